uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N_REQ byte-stream requesters using round-robin arbitration with per-packet grant locking.
- Each requester presents bytes on a valid/ready handshake and marks the final byte of a packet with req_last.
- The arbiter drives tx_start/tx_din into the serializer and sequences on its tx_done_tick, so packets from different requesters never interleave on the line.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DBIT, 8: data bits per UART frame; must match the serializer.
- LOCK_TIMEOUT, 65535: clk cycles a locked owner may leave req_valid low before the lock is forcibly released.
- TW, 16: width of the timeout counter; requires LOCK_TIMEOUT < 2**TW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT]
- req_last  in  N_REQ  byte is last of packet; qualified by req_valid
- req_ready  out  N_REQ  one-hot, single-cycle accept pulse
- tx_start  out  1  one-cycle start pulse to serializer
- tx_din  out  DBIT  byte to serializer; registered, held until the next load
- tx_done_tick  in  1  one-cycle pulse from serializer at end of stop bit
- grant  out  N_REQ  one-hot current owner; all zero when no owner
- busy  out  1  high in any state other than IDLE
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; tx_start=0, tx_din=0, req_ready=0, grant=0, busy=0, lock_timeout=0; rr pointer=0; locked=0; timeout counter=0.
- All outputs are registered. No combinational path from req_* to tx_*.

States:
- IDLE: if any req_valid, pick the winner by round-robin: the first valid index at or after ptr, wrapping modulo N_REQ.
  - Next cycle: grant=winner, tx_din=winner's data, tx_start=1, req_ready[winner]=1; go to WAIT.
  - Latency from req_valid rising in IDLE to tx_start is 1 cycle.
- WAIT: hold tx_din, keep tx_start=0, and wait for tx_done_tick. Then:
  - If the accepted byte had req_last=1: clear locked, set ptr=owner+1 (mod N_REQ), clear grant, go to IDLE. A new arbitration can issue tx_start on the second cycle after done.
  - Otherwise: set locked and go to HOLD.
- HOLD (owner locked mid-packet):
  - If req_valid[owner]: next cycle load that byte (tx_start, req_ready[owner]) and go to WAIT. Other requesters are ignored.
  - Else increment the timeout counter. On reaching LOCK_TIMEOUT: pulse lock_timeout, clear locked and grant, set ptr=owner+1, go to IDLE.
  - The counter clears on every entry into HOLD.
- tx_start is never asserted while the serializer is mid-frame. Exactly one tx_start per tx_done_tick, after the first.
- req_ready and tx_start assert in the same cycle. The byte is captured from req_data at that edge. The requester must hold data stable while req_valid=1 and may change it the cycle after req_ready.
- A tx_done_tick arriving outside WAIT is ignored.
- req_valid dropping in the same cycle as the load decision: the decision uses the registered sample from the previous cycle, so the requester must not withdraw valid without a ready.
- Single requester with req_last=1 on every byte: ptr advances but the same requester wins again. There is no bubble beyond the 1-cycle IDLE pass.
- Reset mid-packet: the arbiter returns to IDLE with the lock dropped. The serializer must share the same reset.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/WAIT/HOLD as 2-bit localparams
  - default DBIT
  - LOCK_TIMEOUT default
- Sub-module uart_rr_pick (combinational): inputs req[N_REQ] and ptr; outputs one-hot winner and a found flag. Implemented with a double-width mask-and-priority scheme. Verified standalone.

Test Plan:
- Single byte: req_valid[0]=1, data=0x55, last=1 → tx_start and req_ready[0] one cycle later with tx_din=0x55; grant=0001 until the done tick, then IDLE and ptr=1.
- Fairness: all four requesters valid with last=1 on every byte, ptr=0 after reset → grant order 0,1,2,3,0 across successive done ticks.
- Packet lock: requester 2 sends 3 bytes (0xA1, 0xA2, 0xA3, last on the third) while requester 1 is continuously valid → no req_ready[1] until after the done for 0xA3; requester 3 is next if valid, otherwise 0, then 1.
- Timeout: with LOCK_TIMEOUT=20, requester 1 sends a byte with last=0 then drops valid → lock_timeout pulses 20 cycles after entering HOLD; grant=0; requester 2 is served next.
- Reset mid-packet: assert reset_n=0 in WAIT → all outputs 0 immediately (asynchronously). After release, requester 0 wins first.
- Stray done: inject tx_done_tick in IDLE and in HOLD → no state change and no tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART transmit arbiter slice.
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int UART_DBIT         = 8;
    localparam int UART_LOCK_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } arb_state_t;

    // Round-robin successor of a requester index.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping; combinational.
// Double-width copy of req masked below ptr, then lowest-set-bit isolation and fold.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic             found
);

    localparam int W = 2 * N_REQ;

    logic [W-1:0] dbl;
    logic [W-1:0] mask;
    logic [W-1:0] masked;
    logic [W-1:0] lowest;

    assign dbl    = {req, req};
    assign mask   = ~(({{(W-1){1'b0}}, 1'b1} << ptr) - W'(1));
    assign masked = dbl & mask;
    // The upper copy always survives the mask, so any request wraps correctly.
    assign lowest = masked & (~masked + W'(1));
    assign winner = lowest[N_REQ-1:0] | lowest[W-1:N_REQ];
    assign found  = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART serializer; all outputs registered.
// Load 1 cycle after valid in IDLE; one byte per tx_done_tick; others stall until release.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DBIT         = UART_DBIT,
    parameter int LOCK_TIMEOUT = UART_LOCK_TIMEOUT,
    parameter int TW           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DBIT-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  tx_start,
    output logic [DBIT-1:0]       tx_din,
    input  logic                  tx_done_tick,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  lock_timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    succ;
    logic [N_REQ-1:0] win_oh;
    logic             found;
    logic             last_q;
    logic [TW-1:0]    tmo_cnt;

    uart_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (win_oh),
        .found  (found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) win_idx = IW'(i);
        end
    end

    assign succ = IW'(next_idx(int'(owner), N_REQ));

    // Being in HOLD is what "locked" means; there is no separate lock flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            last_q       <= 1'b0;
            tmo_cnt      <= '0;
            tx_start     <= 1'b0;
            tx_din       <= '0;
            req_ready    <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            req_ready    <= '0;
            lock_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= win_idx;
                        grant     <= win_oh;
                        req_ready <= win_oh;
                        tx_din    <= req_data[win_idx*DBIT +: DBIT];
                        last_q    <= req_last[win_idx];
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (last_q) begin
                            ptr   <= succ;
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (req_valid[owner]) begin
                        req_ready <= grant;
                        tx_din    <= req_data[owner*DBIT +: DBIT];
                        last_q    <= req_last[owner];
                        tx_start  <= 1'b1;
                        state     <= WAIT;
                    end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        lock_timeout <= 1'b1;
                        ptr          <= succ;
                        grant        <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
